// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one synchronous single-port SRAM (1-cycle read latency) between the
// fetch (inst, read-only) and memory-stage (data, read/write) requesters.
// The data port has priority, bounded by a starvation guard for the inst port.
// Each port has a one-entry return buffer, so a stalled consumer never loses a
// response.

module sram_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        inst_rready,

    input  logic        data_req,
    input  logic [3:0]  data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    input  logic        data_rready,

    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic        fly_inst;
    logic        fly_data;
    logic        fly_wr;
    logic        buf_inst;
    logic        buf_data;
    logic [31:0] bufdata_inst;
    logic [31:0] bufdata_data;
    logic [3:0]  starve_cnt;

    logic        eligible_inst;
    logic        eligible_data;
    logic        want_inst;
    logic        want_data;
    logic        grant_inst;
    logic        grant_data;

    // Response outputs: buffered data wins over the live SRAM output.
    always_comb begin
        inst_data_ok = fly_inst | buf_inst;
        data_data_ok = fly_data | buf_data;

        inst_rdata = 32'h0;
        if (buf_inst)
            inst_rdata = bufdata_inst;
        else if (fly_inst)
            inst_rdata = sram_rdata;

        data_rdata = 32'h0;
        if (buf_data)
            data_rdata = bufdata_data;
        else if (fly_data && !fly_wr)
            data_rdata = sram_rdata;
    end

    // Arbitration: eligibility depends only on state and rready, never on
    // sram_rdata, so addr_ok has no path from the SRAM read data.
    always_comb begin
        eligible_inst = ~(fly_inst | buf_inst) | (inst_data_ok & inst_rready);
        eligible_data = ~(fly_data | buf_data) | (data_data_ok & data_rready);

        want_inst = ~rst & inst_req & eligible_inst;
        want_data = ~rst & data_req & eligible_data;

        grant_data = want_data & ~(want_inst & (starve_cnt == LIMIT));
        grant_inst = want_inst & ~grant_data;

        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
    end

    // SRAM drive: muxed from the granted port, quiet when idle.
    always_comb begin
        sram_en    = grant_inst | grant_data;
        sram_we    = 4'h0;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        if (grant_data) begin
            sram_we    = data_we;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end else if (grant_inst) begin
            sram_addr  = inst_addr;
        end
    end

    // In-flight flags: set by a grant, live for exactly the response cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fly_inst <= 1'b0;
            fly_data <= 1'b0;
            fly_wr   <= 1'b0;
        end else begin
            fly_inst <= grant_inst;
            fly_data <= grant_data;
            fly_wr   <= grant_data & (data_we != 4'h0);
        end
    end

    // Inst return buffer: capture an unconsumed response, free it on consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_inst     <= 1'b0;
            bufdata_inst <= 32'h0;
        end else if (fly_inst && !inst_rready) begin
            buf_inst     <= 1'b1;
            bufdata_inst <= inst_rdata;
        end else if (buf_inst && inst_rready) begin
            buf_inst     <= 1'b0;
        end
    end

    // Data return buffer: same policy as the inst side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_data     <= 1'b0;
            bufdata_data <= 32'h0;
        end else if (fly_data && !data_rready) begin
            buf_data     <= 1'b1;
            bufdata_data <= data_rdata;
        end else if (buf_data && data_rready) begin
            buf_data     <= 1'b0;
        end
    end

    // Starvation counter: counts consecutive contested losses of the inst port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'h0;
        end else if (grant_inst || !inst_req) begin
            starve_cnt <= 4'h0;
        end else if (eligible_inst) begin
            if (starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
// Self-checking bench: a vector table for the arbitration sequence, hand
// sequences for backpressure / write / reset, and a randomized phase checked
// against a transaction-level reference model with a shadow memory.

module tb_sram_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        inst_rready;
    logic        data_req;
    logic [3:0]  data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        data_rready;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int checks = 0;
    int errors = 0;

    sram_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .inst_rready  (inst_rready),
        .data_req     (data_req),
        .data_we      (data_we),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .data_rready  (data_rready),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM device model: 16 words, 1-cycle read latency, junk output when not reading.
    logic [31:0] mem [16];
    logic [31:0] sram_q;
    logic        mem_load;
    logic        ovr_en;
    logic [31:0] ovr_val;

    function automatic logic [31:0] initWord(input int i);
        return 32'hA5000000 ^ (32'(i) * 32'h01030507);
    endfunction

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= initWord(i);
        end else if (sram_en && sram_we != 4'h0) begin
            for (int b = 0; b < 4; b++)
                if (sram_we[b]) mem[sram_addr[5:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
        if (sram_en && sram_we == 4'h0)
            sram_q <= mem[sram_addr[5:2]];
        else
            sram_q <= $urandom;
    end

    assign sram_rdata = ovr_en ? ovr_val : sram_q;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr, input logic irr,
                                 input logic dreq, input logic [3:0] we, input logic [31:0] daddr,
                                 input logic [31:0] wdata, input logic drr);
        inst_req    = ireq;
        inst_addr   = iaddr;
        inst_rready = irr;
        data_req    = dreq;
        data_we     = we;
        data_addr   = daddr;
        data_wdata  = wdata;
        data_rready = drr;
    endtask

    // Advance to 1 time unit after the next rising edge, where inputs are driven.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       ireq;
        logic       dreq;
        logic       irr;
        logic       drr;
        logic       e_iaok;
        logic       e_daok;
        logic       e_idok;
        logic       e_ddok;
    } vec_t;

    vec_t vecs[13];

    // Reference-model state (transaction level).
    logic        m_pend_i, m_pend_d;
    logic [31:0] m_val_i, m_val_d;
    int          m_starve;
    logic [31:0] shadow [16];

    initial begin
        logic        e_i, e_d, w_i, w_d, g_i, g_d;
        logic [31:0] exp_addr, exp_wdata;
        logic [3:0]  exp_we;

        mem_load = 1'b0;
        ovr_en   = 1'b0;
        ovr_val  = 32'h0;
        rst      = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        #1;
        mem_load = 1'b1;
        nextCycle();
        mem_load = 1'b0;
        // Reset state while rst is held, even with requests present.
        applyStimulus(1'b1, 32'h1c000000, 1'b1, 1'b1, 4'hf, 32'h1000, 32'h1, 1'b1);
        #1;
        checkOutput("rst_iaok", inst_addr_ok, 0);
        checkOutput("rst_daok", data_addr_ok, 0);
        checkOutput("rst_sram_en", sram_en, 0);
        checkOutput("rst_sram_we", sram_we, 0);
        checkOutput("rst_idok", inst_data_ok, 0);
        checkOutput("rst_ddok", data_data_ok, 0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        nextCycle();
        rst = 1'b0;

        // Arbitration table: inst read, contention, 4-cycle starvation, recovery.
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int v = 0; v < 13; v++) begin
            nextCycle();
            applyStimulus(vecs[v].ireq, 32'h1c000000, vecs[v].irr,
                          vecs[v].dreq, 4'h0, 32'h1000, 32'h0, vecs[v].drr);
            #1;
            checkOutput($sformatf("vec%0d_iaok", v), inst_addr_ok, vecs[v].e_iaok);
            checkOutput($sformatf("vec%0d_daok", v), data_addr_ok, vecs[v].e_daok);
            checkOutput($sformatf("vec%0d_idok", v), inst_data_ok, vecs[v].e_idok);
            checkOutput($sformatf("vec%0d_ddok", v), data_data_ok, vecs[v].e_ddok);
            checkOutput($sformatf("vec%0d_en", v), sram_en, vecs[v].e_iaok | vecs[v].e_daok);
            if (vecs[v].e_iaok)
                checkOutput($sformatf("vec%0d_addr", v), sram_addr, 32'h1c000000);
            if (vecs[v].e_daok)
                checkOutput($sformatf("vec%0d_addr", v), sram_addr, 32'h1000);
        end

        // Backpressure: response held in the buffer while the SRAM output changes.
        ovr_en  = 1'b1;
        ovr_val = 32'h11111111;
        nextCycle();
        applyStimulus(1'b1, 32'h1c000010, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        #1;
        checkOutput("bp_grant", inst_addr_ok, 1);
        nextCycle();
        applyStimulus(1'b0, 32'h1c000010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        #1;
        checkOutput("bp_resp_ok", inst_data_ok, 1);
        checkOutput("bp_resp_data", inst_rdata, 32'h11111111);
        nextCycle();
        ovr_val = 32'h22222222;
        applyStimulus(1'b1, 32'h1c000014, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        #1;
        checkOutput("bp_hold_ok", inst_data_ok, 1);
        checkOutput("bp_hold_data", inst_rdata, 32'h11111111);
        checkOutput("bp_hold_nogrant", inst_addr_ok, 0);
        nextCycle();
        applyStimulus(1'b1, 32'h1c000014, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        #1;
        checkOutput("bp_drain_data", inst_rdata, 32'h11111111);
        checkOutput("bp_regrant", inst_addr_ok, 1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        #1;
        checkOutput("bp_new_ok", inst_data_ok, 1);
        checkOutput("bp_new_data", inst_rdata, 32'h22222222);

        // Write: SRAM sees the write, response carries zero data.
        ovr_val = 32'h55555555;
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'hf, 32'h1000, 32'hdeadbeef, 1'b1);
        #1;
        checkOutput("wr_daok", data_addr_ok, 1);
        checkOutput("wr_sram_we", sram_we, 4'hf);
        checkOutput("wr_sram_wdata", sram_wdata, 32'hdeadbeef);
        checkOutput("wr_sram_addr", sram_addr, 32'h1000);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        #1;
        checkOutput("wr_ddok", data_data_ok, 1);
        checkOutput("wr_rdata", data_rdata, 32'h0);

        // Reset between grant and response.
        nextCycle();
        applyStimulus(1'b1, 32'h1c000000, 1'b1, 1'b1, 4'h0, 32'h1004, 32'h0, 1'b1);
        #1;
        checkOutput("mid_daok", data_addr_ok, 1);
        nextCycle();
        rst = 1'b1;
        #1;
        checkOutput("mid_ddok", data_data_ok, 0);
        checkOutput("mid_drdata", data_rdata, 0);
        checkOutput("mid_iaok", inst_addr_ok, 0);
        checkOutput("mid_daok0", data_addr_ok, 0);
        checkOutput("mid_en", sram_en, 0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            nextCycle();
            checkOutput($sformatf("post_rst_idok%0d", k), inst_data_ok, 0);
            checkOutput($sformatf("post_rst_ddok%0d", k), data_data_ok, 0);
        end
        ovr_en = 1'b0;

        // Randomized phase against the reference model.
        rst      = 1'b1;
        mem_load = 1'b1;
        nextCycle();
        mem_load = 1'b0;
        for (int i = 0; i < 16; i++) shadow[i] = initWord(i);
        m_pend_i = 1'b0;
        m_pend_d = 1'b0;
        m_val_i  = 32'h0;
        m_val_d  = 32'h0;
        m_starve = 0;
        rst      = 1'b0;

        for (int c = 0; c < 600; c++) begin
            nextCycle();
            applyStimulus(($urandom % 4) != 0, 32'h1c000000 + 32'($urandom % 16) * 4,
                          ($urandom % 4) != 0,
                          ($urandom % 2) != 0,
                          (($urandom % 10) < 3) ? 4'($urandom_range(1, 15)) : 4'h0,
                          32'h1000 + 32'($urandom % 16) * 4, $urandom,
                          ($urandom % 4) != 0);
            #1;
            e_i = !m_pend_i || inst_rready;
            e_d = !m_pend_d || data_rready;
            w_i = inst_req && e_i;
            w_d = data_req && e_d;
            if (w_i && w_d) begin
                g_i = (m_starve == LIMIT);
                g_d = !g_i;
            end else begin
                g_i = w_i;
                g_d = w_d;
            end
            exp_addr  = g_d ? data_addr : (g_i ? inst_addr : 32'h0);
            exp_wdata = g_d ? data_wdata : 32'h0;
            exp_we    = g_d ? data_we : 4'h0;

            checkOutput("rnd_iaok", inst_addr_ok, g_i);
            checkOutput("rnd_daok", data_addr_ok, g_d);
            checkOutput("rnd_idok", inst_data_ok, m_pend_i);
            checkOutput("rnd_ddok", data_data_ok, m_pend_d);
            checkOutput("rnd_irdata", inst_rdata, m_pend_i ? m_val_i : 32'h0);
            checkOutput("rnd_drdata", data_rdata, m_pend_d ? m_val_d : 32'h0);
            checkOutput("rnd_en", sram_en, g_i | g_d);
            checkOutput("rnd_addr", sram_addr, exp_addr);
            checkOutput("rnd_we", sram_we, exp_we);
            checkOutput("rnd_wdata", sram_wdata, exp_wdata);

            if (m_pend_i && inst_rready) m_pend_i = 1'b0;
            if (m_pend_d && data_rready) m_pend_d = 1'b0;
            if (g_i) begin
                m_pend_i = 1'b1;
                m_val_i  = shadow[inst_addr[5:2]];
            end
            if (g_d) begin
                m_pend_d = 1'b1;
                if (data_we == 4'h0) begin
                    m_val_d = shadow[data_addr[5:2]];
                end else begin
                    m_val_d = 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (data_we[b]) shadow[data_addr[5:2]][8*b +: 8] = data_wdata[8*b +: 8];
                end
            end
            if (g_i || !inst_req)
                m_starve = 0;
            else if (e_i && m_starve < LIMIT)
                m_starve = m_starve + 1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one synchronous single-port SRAM (1-cycle read latency) between the fetch requester (inst port, read-only) and the memory-stage requester (data port, read/write).
- Sits between the pipeline stages and the SRAM. Replaces the separate inst/data SRAM paths when the core runs with a unified memory.
- Uses a req/addr_ok/data_ok handshake. Data has priority over inst, with a starvation guard. Each port has a one-entry return buffer for backpressure.

Parameters:
- STARVE_LIMIT, 4: number of consecutive lost cycles, while the inst port is requesting and eligible, after which the inst port wins the next contested cycle. Range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- inst_req  in  1  inst read request.
- inst_addr  in  32  inst read address.
- inst_addr_ok  out  1  inst request accepted this cycle.
- inst_data_ok  out  1  inst read data valid on inst_rdata.
- inst_rdata  out  32  inst read data.
- inst_rready  in  1  fetch consumes inst_rdata this cycle.
- data_req  in  1  data request.
- data_we  in  4  byte write enables; 0 means read.
- data_addr  in  32  data address.
- data_wdata  in  32  data write data.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  data response valid.
- data_rdata  out  32  data read data.
- data_rready  in  1  memory stage consumes the response this cycle.
- sram_en  out  1  SRAM enable.
- sram_we  out  4  SRAM byte write enables.
- sram_addr  out  32  SRAM address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_en.

Behaviour:
- Per-port state (X = inst or data):
  - fly_X: request issued last cycle.
  - buf_X: a response is held in the return buffer.
  - bufdata_X: 32-bit buffered response data.
- Arbiter state: starve_cnt (4 bits), plus fly_wr (the in-flight data access is a write).
- Eligibility: eligible_X = ~(fly_X | buf_X) | (X_data_ok & X_rready). At most one outstanding access per port; a new request may be issued in the same cycle the previous response is consumed.
- Grant (combinational, same cycle):
  - Only one port eligible and requesting: that port wins.
  - Both eligible and requesting: data wins, unless starve_cnt == STARVE_LIMIT, in which case inst wins.
  - X_addr_ok = grant_X.
- SRAM drive:
  - sram_en = grant_inst | grant_data.
  - sram_addr and sram_wdata come from the granted port; both are 0 when idle.
  - sram_we = data_we when grant_data, else 4'h0.
- Response, cycle T+1 after a grant in cycle T:
  - X_data_ok = fly_X | buf_X.
  - X_rdata = bufdata_X if buf_X; otherwise sram_rdata for a read, 32'h0 for a write.
  - fly_X and buf_X are never both set.
- Buffering:
  - fly_X & ~X_rready at the clock edge: buf_X <= 1 and bufdata_X <= the current X_rdata.
  - buf_X & X_rready: buf_X <= 0.
  - While buf_X is set, sram_rdata changes do not affect X_rdata.
- Flag updates: fly_X <= grant_X. fly_wr <= grant_data & (data_we != 0).
- starve_cnt:
  - Clears when inst is granted or inst_req is low.
  - Otherwise increments (saturating at STARVE_LIMIT) when inst_req & eligible_inst & ~grant_inst.
  - Otherwise holds.
- Reset (asynchronous, any time, including mid-access): fly_*, buf_*, fly_wr, starve_cnt and bufdata_* all clear.
  - While rst is high: all *_addr_ok, *_data_ok and sram_en are 0; sram_we = 0; rdata outputs = 0.
  - In-flight accesses are dropped; no data_ok appears after reset release.
  - Requests are ignored while rst is high.
- No combinational path from sram_rdata to any *_addr_ok.

Test Plan:
- Inst read: inst_req=1, addr 0x1c000000 in cycle T, SRAM returns 0x02800c0c.
  -> inst_addr_ok=1, sram_en=1, sram_addr=0x1c000000 in T; inst_data_ok=1, inst_rdata=0x02800c0c in T+1.
- Contention: inst_req and data_req (read, addr 0x1000) both high in T.
  -> data_addr_ok=1 and inst_addr_ok=0 in T; inst granted in T+1; responses arrive T+1 (data) and T+2 (inst).
- Starvation, STARVE_LIMIT=4: data_req and data_rready held high, inst_req held high.
  -> data wins 4 consecutive cycles; inst_addr_ok=1 on the 5th; starve_cnt returns to 0.
- Backpressure: inst_rready=0 at response cycle, sram_rdata=0x11111111, then SRAM output changes to 0x22222222.
  -> inst_data_ok stays 1 with inst_rdata=0x11111111; no inst grant; when inst_rready=1 and inst_req=1, the response is consumed and inst is re-granted in the same cycle.
- Write: data_we=4'hf, addr 0x1000, wdata 0xdeadbeef in T.
  -> sram_we=4'hf, sram_wdata=0xdeadbeef in T; data_data_ok=1, data_rdata=0 in T+1.
- Reset mid-access: assert rst asynchronously between grant and response.
  -> all outputs 0 immediately; after release, no data_ok without a new grant.
